mac_lane_array: RTL and testbench
=================================

// Module: mac_lane_array
// PURPOSE
//  Parametrised multi-lane MAC datapath: NB_LANES signed MACs share one broadcast activation,
//  each with its own weight, and accumulate over ACC_LEN taps. Sits between the controller FSM
//  and the operand/partial-sum streams of the accelerator top level.
//  Adds per-output tap counting, optional partial-sum preload, output shift/saturation and an
//  output valid/ready handshake with back-pressure.
// PARAMETERS
//  IO_DATA_WIDTH       16  width of activation, each weight and each saturated output lane
//  ACCUMULATION_WIDTH  32  per-lane accumulator and partial-sum width
//  NB_LANES            4   number of parallel MAC lanes (output channels per pass)
//  ACC_LEN             9   operand pairs accumulated per output (>=1)
//  OUTPUT_SCALE        0   arithmetic right shift applied before saturation (0..ACCUMULATION_WIDTH-1)
// PORTS
//  clk         in   1                              clock
//  rst_in      in   1                              synchronous reset, active-high
//  start       in   1                              begin one accumulation pass
//  psum_en     in   1                              at start: preload psum_in (1) or zero (0)
//  psum_in     in   NB_LANES*ACCUMULATION_WIDTH    packed partial sums, lane l at [l*AW +: AW]
//  op_a        in   IO_DATA_WIDTH                  signed activation, broadcast to all lanes
//  op_b        in   NB_LANES*IO_DATA_WIDTH         packed signed weights, lane l at [l*IW +: IW]
//  op_valid    in   1                              operand pair valid
//  op_ready    out  1                              operand pair accepted when op_valid&op_ready
//  out_data    out  NB_LANES*IO_DATA_WIDTH         packed saturated results
//  out_acc     out  NB_LANES*ACCUMULATION_WIDTH    packed raw accumulators (for ext memory write-back)
//  out_valid   out  1                              results valid
//  out_ready   in   1                              consumer accepts when out_valid&out_ready
//  running     out  1                              high in ACCUM and HOLD
//  tap_cnt     out  $clog2(ACC_LEN+1)              operand pairs consumed in current pass
// BEHAVIOUR
//  - Reset (rst_in=1 at clk edge, any state): state=IDLE, accumulators=0, tap_cnt=0; op_ready=0,
//    out_valid=0, running=0, out_data=0, out_acc=0. Reset mid-pass discards the pass.
//  - States: IDLE -> ACCUM -> HOLD -> IDLE/ACCUM.
//  - IDLE: op_ready=0 (operands not consumed). start=1 -> ACCUM; same edge acc[l] <= psum_en ?
//    psum_in[l] : 0; tap_cnt <= 0.
//  - ACCUM: op_ready=1, start ignored. On handshake: acc[l] <= acc[l] + sext(op_a*op_b[l]);
//    product is full 2*IO_DATA_WIDTH signed, sign-extended/truncated to ACCUMULATION_WIDTH;
//    accumulation wraps modulo 2^ACCUMULATION_WIDTH (no saturation). tap_cnt++.
//    Handshake with tap_cnt==ACC_LEN-1 -> HOLD (acc holds final value next cycle).
//    op_valid=0 cycles: no change (bubbles allowed, latency 1 cycle per accepted pair).
//  - HOLD: out_valid=1, op_ready=0, accumulators frozen, tap_cnt=ACC_LEN. out_data/out_acc stable
//    while out_valid&!out_ready. out_ready=1: start=1 same cycle -> ACCUM with preload as in IDLE
//    (back-to-back passes, no idle cycle); else -> IDLE.
//  - out_acc[l] = acc[l]; out_data[l] = sat(acc[l] >>> OUTPUT_SCALE) to signed IO_DATA_WIDTH:
//    > 2^(IW-1)-1 -> 2^(IW-1)-1; < -2^(IW-1) -> -2^(IW-1). Both combinational from acc;
//    driven 0 outside HOLD.
//  - Latency: last pair accepted at edge t -> out_valid high in cycle after t.
//  - ACC_LEN=1: single handshake ACCUM -> HOLD.
// STRUCTURE
//  - Package mac_array_pkg: state enum (IDLE, ACCUM, HOLD), function sat_shift(acc, scale) -> IW.
//  - Sub-module mac_lane (one accumulator: preload, multiply-add, sat_shift), generate loop over
//    NB_LANES; top holds FSM, tap counter and handshake logic only.
// TESTING
//  1 Reset: rst_in held 3 cycles mid-ACCUM -> IDLE, out_valid=0, op_ready=0, tap_cnt=0.
//  2 Basic: psum_en=0, ACC_LEN=9, a=2, b={1,-1,3,0} x9 -> out_data={18,-18,54,0}, out_valid 1 cycle
//    after 9th handshake.
//  3 Preload+bubbles: psum_en=1, psum_in={100,0,0,-5}, op_valid toggled 1/0, a=1,b={1,1,1,1} x9
//    -> out_acc={109,9,9,4}; tap_cnt stalls on bubbles.
//  4 Saturation/scale: OUTPUT_SCALE=2, a=32767,b=32767 x9 -> out_data=32767 per lane; a=-32768,
//    b=32767 -> -32768; out_acc checked against modulo-2^32 model.
//  5 Back-pressure: out_ready=0 for 5 cycles in HOLD -> outputs stable, op_ready=0; op_valid
//    ignored; then out_ready=1 with start=1 -> next pass begins next cycle, no lost operand.
//  6 Random: 1000 passes, random operands/valid/ready, compare against reference model.

Source files
------------

// File: rtl/mac_array_pkg.sv
// Shared types and helpers for the multi-lane MAC array.
// The widths are generic, so sat_shift works on a 64-bit sign-extended accumulator.
package mac_array_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // Arithmetic right shift, then clamp to the signed range of an iw-bit result.
    function automatic logic signed [63:0] sat_shift(input logic signed [63:0] acc,
                                                     input int scale,
                                                     input int iw);
        logic signed [63:0] s;
        logic signed [63:0] mx;
        logic signed [63:0] mn;
        s  = acc >>> scale;
        mx = (64'sd1 <<< (iw - 1)) - 64'sd1;
        mn = -(64'sd1 <<< (iw - 1));
        if (s > mx)
            return mx;
        else if (s < mn)
            return mn;
        return s;
    endfunction

endpackage

// File: rtl/mac_lane_array_if.sv
// Operand, partial-sum and result streams of the MAC lane array.
interface mac_lane_array_if #(
    parameter int IW = 16,
    parameter int AW = 32,
    parameter int NL = 4,
    parameter int TW = 4
);
    logic                   start;
    logic                   psum_en;
    logic [NL-1:0][AW-1:0]  psum_in;
    logic [IW-1:0]          op_a;
    logic [NL-1:0][IW-1:0]  op_b;
    logic                   op_valid;
    logic                   op_ready;
    logic [NL-1:0][IW-1:0]  out_data;
    logic [NL-1:0][AW-1:0]  out_acc;
    logic                   out_valid;
    logic                   out_ready;
    logic                   running;
    logic [TW-1:0]          tap_cnt;

    modport master (
        output start, psum_en, psum_in, op_a, op_b, op_valid, out_ready,
        input  op_ready, out_data, out_acc, out_valid, running, tap_cnt
    );

    modport slave (
        input  start, psum_en, psum_in, op_a, op_b, op_valid, out_ready,
        output op_ready, out_data, out_acc, out_valid, running, tap_cnt
    );
endinterface

// File: rtl/mac_lane.sv
// One MAC lane: preload, signed multiply-accumulate (wrapping) and shifted saturation.
module mac_lane
    import mac_array_pkg::*;
#(
    parameter int IW    = 16,
    parameter int AW    = 32,
    parameter int SCALE = 0
) (
    input  logic          clk,
    input  logic          rst_in,
    input  logic          load,
    input  logic          psum_en,
    input  logic [AW-1:0] psum,
    input  logic          mac_en,
    input  logic [IW-1:0] a,
    input  logic [IW-1:0] b,
    output logic [AW-1:0] acc,
    output logic [IW-1:0] sat
);
    logic signed [AW-1:0]   acc_q;
    logic signed [2*IW-1:0] prod;
    logic signed [AW-1:0]   prod_ext;
    logic signed [63:0]     sat_wide;

    // Size cast on a signed value sign-extends or truncates as needed.
    assign prod     = $signed(a) * $signed(b);
    assign prod_ext = AW'(prod);

    always_ff @(posedge clk) begin
        if (rst_in)
            acc_q <= '0;
        else if (load)
            acc_q <= psum_en ? $signed(psum) : '0;
        else if (mac_en)
            acc_q <= acc_q + prod_ext;
    end

    assign sat_wide = sat_shift(64'(acc_q), SCALE, IW);
    assign acc      = acc_q;
    assign sat      = IW'(sat_wide);
endmodule

// File: rtl/mac_lane_array.sv
// NB_LANES signed MACs sharing a broadcast activation; top holds the pass FSM,
// the tap counter and both handshakes, lanes hold the arithmetic.
module mac_lane_array
    import mac_array_pkg::*;
#(
    parameter int IO_DATA_WIDTH      = 16,
    parameter int ACCUMULATION_WIDTH = 32,
    parameter int NB_LANES           = 4,
    parameter int ACC_LEN            = 9,
    parameter int OUTPUT_SCALE       = 0
) (
    input  logic             clk,
    input  logic             rst_in,
    mac_lane_array_if.slave  bus
);
    localparam int IW = IO_DATA_WIDTH;
    localparam int AW = ACCUMULATION_WIDTH;
    localparam int TW = $clog2(ACC_LEN + 1);

    state_t                       state;
    logic [TW-1:0]                tap_q;
    logic                         op_ready_q;
    logic                         out_valid_q;
    logic                         running_q;
    logic                         accept;
    logic                         load;
    logic [NB_LANES-1:0][AW-1:0]  acc;
    logic [NB_LANES-1:0][IW-1:0]  sat;

    // op_ready_q is high exactly in ACCUM, out_valid_q exactly in HOLD.
    assign accept = op_ready_q & bus.op_valid;
    assign load   = bus.start & ((state == IDLE) | ((state == HOLD) & bus.out_ready));

    always_ff @(posedge clk) begin
        if (rst_in) begin
            state       <= IDLE;
            tap_q       <= '0;
            op_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            running_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state      <= ACCUM;
                        tap_q      <= '0;
                        op_ready_q <= 1'b1;
                        running_q  <= 1'b1;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        tap_q <= tap_q + 1'b1;
                        if (tap_q == TW'(ACC_LEN - 1)) begin
                            state       <= HOLD;
                            op_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        if (bus.start) begin
                            state      <= ACCUM;
                            tap_q      <= '0;
                            op_ready_q <= 1'b1;
                        end else begin
                            state     <= IDLE;
                            running_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state       <= IDLE;
                    op_ready_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                    running_q   <= 1'b0;
                end
            endcase
        end
    end

    for (genvar l = 0; l < NB_LANES; l++) begin : g_lane
        mac_lane #(
            .IW    (IW),
            .AW    (AW),
            .SCALE (OUTPUT_SCALE)
        ) u_lane (
            .clk     (clk),
            .rst_in  (rst_in),
            .load    (load),
            .psum_en (bus.psum_en),
            .psum    (bus.psum_in[l]),
            .mac_en  (accept),
            .a       (bus.op_a),
            .b       (bus.op_b[l]),
            .acc     (acc[l]),
            .sat     (sat[l])
        );
    end

    assign bus.op_ready  = op_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.running   = running_q;
    assign bus.tap_cnt   = tap_q;
    assign bus.out_acc   = out_valid_q ? acc : '0;
    assign bus.out_data  = out_valid_q ? sat : '0;
endmodule

// File: tb/tb_mac_lane_array.sv
// Bench for mac_lane_array: two instances (scale 0 and scale 2) share all inputs;
// a scoreboard of expected results is pushed per pass and popped at the output handshake.
module tb_mac_lane_array;
    localparam int IW = 16;
    localparam int AW = 32;
    localparam int NL = 4;
    localparam int AL = 9;
    localparam int TW = $clog2(AL + 1);

    typedef logic [NL-1:0][AW-1:0] accv_t;
    typedef logic [NL-1:0][IW-1:0] datv_t;
    typedef logic [IW-1:0] av_t [AL];
    typedef datv_t bv_t [AL];
    typedef struct {
        accv_t acc;
        datv_t d0;
        datv_t d2;
    } exp_t;

    logic clk = 1'b0;
    logic rst_in;
    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];
    accv_t m_acc;

    always #5 clk = ~clk;

    mac_lane_array_if #(.IW(IW), .AW(AW), .NL(NL), .TW(TW)) b0 ();
    mac_lane_array_if #(.IW(IW), .AW(AW), .NL(NL), .TW(TW)) b2 ();

    assign b2.start     = b0.start;
    assign b2.psum_en   = b0.psum_en;
    assign b2.psum_in   = b0.psum_in;
    assign b2.op_a      = b0.op_a;
    assign b2.op_b      = b0.op_b;
    assign b2.op_valid  = b0.op_valid;
    assign b2.out_ready = b0.out_ready;

    mac_lane_array #(.IO_DATA_WIDTH(IW), .ACCUMULATION_WIDTH(AW), .NB_LANES(NL),
                     .ACC_LEN(AL), .OUTPUT_SCALE(0)) dut0 (.clk(clk), .rst_in(rst_in), .bus(b0));
    mac_lane_array #(.IO_DATA_WIDTH(IW), .ACCUMULATION_WIDTH(AW), .NB_LANES(NL),
                     .ACC_LEN(AL), .OUTPUT_SCALE(2)) dut2 (.clk(clk), .rst_in(rst_in), .bus(b2));

    function automatic logic [IW-1:0] ref_sat(input logic [AW-1:0] acc, input int sh);
        longint v, mx, mn;
        v  = longint'($signed(acc)) >>> sh;
        mx = (longint'(1) << (IW - 1)) - 1;
        mn = -mx - 1;
        if (v > mx) v = mx;
        else if (v < mn) v = mn;
        return v[IW-1:0];
    endfunction

    function automatic datv_t rand_b();
        datv_t r;
        for (int l = 0; l < NL; l++) r[l] = IW'($urandom);
        return r;
    endfunction

    task automatic do_start(input bit pe, input accv_t ps);
        b0.start   = 1'b1;
        b0.psum_en = pe;
        b0.psum_in = ps;
        m_acc      = pe ? ps : '0;
    endtask

    // mode 0: no bubbles, 1: alternate valid/bubble, 2: random bubbles with pct percent
    task automatic feed(input av_t a, input bv_t b, input int mode, input int pct);
        int k = 0;
        int cyc = 0;
        bit v;
        exp_t e;
        longint pr;
        while (k < AL && cyc < 400) begin
            @(negedge clk);
            b0.start     = 1'b0;
            b0.out_ready = 1'b0;
            v = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : ($urandom_range(99) >= pct);
            b0.op_valid = v;
            b0.op_a     = v ? a[k] : IW'($urandom);
            b0.op_b     = v ? b[k] : rand_b();
            checks++;
            if (b0.op_ready !== 1'b1) begin
                failures++; $display("FAIL feed_op_ready got=%b exp=1", b0.op_ready);
            end
            checks++;
            if (b0.tap_cnt !== TW'(k)) begin
                failures++; $display("FAIL feed_tap_cnt got=%0d exp=%0d", b0.tap_cnt, k);
            end
            checks++;
            if (b0.out_valid !== 1'b0 || b0.running !== 1'b1) begin
                failures++; $display("FAIL feed_status out_valid=%b running=%b exp=0/1", b0.out_valid, b0.running);
            end
            @(posedge clk);
            if (v) begin
                for (int l = 0; l < NL; l++) begin
                    pr = longint'($signed(a[k])) * longint'($signed(b[k][l]));
                    m_acc[l] = m_acc[l] + pr[AW-1:0];
                end
                k++;
            end
            cyc++;
        end
        checks++;
        if (k < AL) begin
            failures++; $display("FAIL feed_timeout taps=%0d exp=%0d", k, AL);
        end
        e.acc = m_acc;
        for (int l = 0; l < NL; l++) begin
            e.d0[l] = ref_sat(m_acc[l], 0);
            e.d2[l] = ref_sat(m_acc[l], 2);
        end
        sb.push_back(e);
    endtask

    // Holds out_ready low for stall cycles (junk operands offered), then accepts the result.
    task automatic drain(input int stall, input bit chain, input bit npe, input accv_t nps);
        exp_t e;
        int g = 0;
        @(negedge clk);
        b0.op_valid = 1'b1;
        b0.op_a     = IW'($urandom);
        b0.op_b     = rand_b();
        checks++;
        if (b0.out_valid !== 1'b1) begin
            failures++; $display("FAIL out_latency out_valid=%b exp=1", b0.out_valid);
        end
        while (b0.out_valid !== 1'b1 && g < 20) begin
            @(negedge clk); g++;
        end
        if (b0.out_valid !== 1'b1 || sb.size() == 0) begin
            checks++; failures++;
            $display("FAIL out_timeout out_valid=%b queued=%0d", b0.out_valid, sb.size());
            return;
        end
        e = sb.pop_front();
        for (int s = 0; s <= stall; s++) begin
            if (s > 0) @(negedge clk);
            b0.out_ready = (s == stall);
            if (s == stall && chain) do_start(npe, nps);
            checks++;
            if (b0.out_valid !== 1'b1 || b0.op_ready !== 1'b0 || b0.tap_cnt !== TW'(AL)) begin
                failures++;
                $display("FAIL hold_status out_valid=%b op_ready=%b tap=%0d exp=1/0/%0d",
                         b0.out_valid, b0.op_ready, b0.tap_cnt, AL);
            end
            checks++;
            if (b0.out_acc !== e.acc) begin
                failures++; $display("FAIL out_acc got=%h exp=%h", b0.out_acc, e.acc);
            end
            checks++;
            if (b0.out_data !== e.d0) begin
                failures++; $display("FAIL out_data_s0 got=%h exp=%h", b0.out_data, e.d0);
            end
            checks++;
            if (b2.out_data !== e.d2) begin
                failures++; $display("FAIL out_data_s2 got=%h exp=%h", b2.out_data, e.d2);
            end
        end
        @(posedge clk);
        if (!chain) begin
            @(negedge clk);
            b0.out_ready = 1'b0;
            b0.op_valid  = 1'b0;
            b0.start     = 1'b0;
            checks++;
            if (b0.out_valid !== 1'b0 || b0.running !== 1'b0 || b0.op_ready !== 1'b0 ||
                b0.out_data !== '0 || b0.out_acc !== '0) begin
                failures++;
                $display("FAIL idle_after_hold out_valid=%b running=%b op_ready=%b data=%h acc=%h exp=0",
                         b0.out_valid, b0.running, b0.op_ready, b0.out_data, b0.out_acc);
            end
        end
    endtask

    task automatic test_reset();
        rst_in       = 1'b1;
        b0.start     = 1'b0;
        b0.psum_en   = 1'b0;
        b0.psum_in   = '0;
        b0.op_a      = '0;
        b0.op_b      = '0;
        b0.op_valid  = 1'b0;
        b0.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (b0.out_valid !== 1'b0 || b0.op_ready !== 1'b0 || b0.running !== 1'b0 ||
            b0.tap_cnt !== '0 || b0.out_data !== '0 || b0.out_acc !== '0) begin
            failures++;
            $display("FAIL reset_state out_valid=%b op_ready=%b running=%b tap=%0d exp=0/0/0/0",
                     b0.out_valid, b0.op_ready, b0.running, b0.tap_cnt);
        end
        rst_in = 1'b0;
        do_start(1'b1, {NL{32'd77}});
        @(negedge clk);
        b0.start    = 1'b0;
        b0.op_valid = 1'b1;
        b0.op_a     = 16'd5;
        b0.op_b     = {NL{16'd3}};
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (b0.tap_cnt !== TW'(3) || b0.running !== 1'b1) begin
            failures++; $display("FAIL pre_reset_tap got=%0d exp=3 running=%b", b0.tap_cnt, b0.running);
        end
        rst_in = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_in = 1'b0;
        checks++;
        if (b0.out_valid !== 1'b0 || b0.op_ready !== 1'b0 || b0.tap_cnt !== '0 || b0.running !== 1'b0) begin
            failures++;
            $display("FAIL midpass_reset out_valid=%b op_ready=%b tap=%0d running=%b exp=0",
                     b0.out_valid, b0.op_ready, b0.tap_cnt, b0.running);
        end
        @(negedge clk);
        checks++;
        if (b0.op_ready !== 1'b0 || b0.tap_cnt !== '0) begin
            failures++; $display("FAIL idle_no_consume op_ready=%b tap=%0d exp=0/0", b0.op_ready, b0.tap_cnt);
        end
        b0.op_valid = 1'b0;
    endtask

    task automatic test_basic();
        av_t a;
        bv_t b;
        datv_t want;
        for (int k = 0; k < AL; k++) begin
            a[k] = 16'd2;
            b[k][0] = 16'd1; b[k][1] = 16'hFFFF; b[k][2] = 16'd3; b[k][3] = 16'd0;
        end
        want[0] = 16'd18; want[1] = 16'hFFEE; want[2] = 16'd54; want[3] = 16'd0;
        @(negedge clk);
        do_start(1'b0, '0);
        feed(a, b, 0, 0);
        @(negedge clk);
        b0.op_valid = 1'b0;
        checks++;
        if (b0.out_valid !== 1'b1 || b0.out_data !== want) begin
            failures++; $display("FAIL basic_result valid=%b got=%h exp=%h", b0.out_valid, b0.out_data, want);
        end
        drain(0, 1'b0, 1'b0, '0);
    endtask

    task automatic test_preload();
        av_t a;
        bv_t b;
        accv_t ps, want;
        for (int k = 0; k < AL; k++) begin
            a[k] = 16'd1;
            b[k] = {NL{16'd1}};
        end
        ps[0] = 32'd100; ps[1] = 32'd0; ps[2] = 32'd0; ps[3] = 32'hFFFF_FFFB;
        want[0] = 32'd109; want[1] = 32'd9; want[2] = 32'd9; want[3] = 32'd4;
        @(negedge clk);
        do_start(1'b1, ps);
        feed(a, b, 1, 0);
        @(negedge clk);
        b0.op_valid = 1'b0;
        checks++;
        if (b0.out_acc !== want) begin
            failures++; $display("FAIL preload_acc got=%h exp=%h", b0.out_acc, want);
        end
        drain(0, 1'b0, 1'b0, '0);
    endtask

    task automatic test_saturation();
        av_t a;
        bv_t b;
        for (int k = 0; k < AL; k++) begin
            a[k] = 16'h7FFF;
            b[k] = {NL{16'h7FFF}};
        end
        @(negedge clk);
        do_start(1'b0, '0);
        feed(a, b, 0, 0);
        @(negedge clk);
        checks++;
        if (b0.out_data !== {NL{16'h7FFF}} || b2.out_data !== {NL{16'h7FFF}}) begin
            failures++; $display("FAIL sat_pos s0=%h s2=%h exp=7fff", b0.out_data, b2.out_data);
        end
        drain(0, 1'b0, 1'b0, '0);
        for (int k = 0; k < AL; k++) a[k] = 16'h8000;
        @(negedge clk);
        do_start(1'b0, '0);
        feed(a, b, 0, 0);
        @(negedge clk);
        checks++;
        if (b0.out_data !== {NL{16'h8000}} || b2.out_data !== {NL{16'h8000}}) begin
            failures++; $display("FAIL sat_neg s0=%h s2=%h exp=8000", b0.out_data, b2.out_data);
        end
        drain(0, 1'b0, 1'b0, '0);
    endtask

    task automatic test_back_to_back();
        av_t a;
        bv_t b;
        accv_t ps;
        for (int k = 0; k < AL; k++) begin
            a[k] = IW'(k + 3);
            b[k] = rand_b();
        end
        ps = {32'd1, 32'd2, 32'hFFFF_FF00, 32'd4};
        @(negedge clk);
        do_start(1'b0, '0);
        feed(a, b, 0, 0);
        drain(5, 1'b1, 1'b1, ps);
        for (int k = 0; k < AL; k++) a[k] = IW'($urandom);
        feed(a, b, 0, 0);
        drain(2, 1'b0, 1'b0, '0);
    endtask

    task automatic test_random();
        av_t a;
        bv_t b;
        bit pe, chain;
        accv_t ps;
        pe = 1'($urandom);
        ps = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        do_start(pe, ps);
        for (int p = 0; p < 1000; p++) begin
            for (int k = 0; k < AL; k++) begin
                a[k] = IW'($urandom);
                b[k] = rand_b();
            end
            feed(a, b, 2, 30);
            pe    = 1'($urandom);
            ps    = {$urandom, $urandom, $urandom, $urandom};
            chain = (p < 999) && ($urandom_range(1) == 1);
            drain($urandom_range(3), chain, pe, ps);
            if (!chain && p < 999) begin
                @(negedge clk);
                do_start(pe, ps);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_preload();
        test_saturation();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
